// File: rtl/mc_defs.sv
// rtl/mc_defs.sv - shared opcodes, state encodings and select codes for the multicycle control FSM
package mc_defs;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BEQ    = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    localparam logic [1:0] SRCB_RT    = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic       pcwrite;
        logic       pcwritecond;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       irwrite;
        logic       regdst;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsource;
        logic [1:0] aluop;
    } ctrl_t;

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - opcode/handshake inputs and control word outputs of the main FSM
interface multicycle_control_if #(
    parameter int OPW = 6,
    parameter int STW = 4
);
    logic [OPW-1:0] op;
    logic           mem_ready;
    logic           pcwrite;
    logic           pcwritecond;
    logic           iord;
    logic           memread;
    logic           memwrite;
    logic           memtoreg;
    logic           irwrite;
    logic           regdst;
    logic           regwrite;
    logic           alusrca;
    logic [1:0]     alusrcb;
    logic [1:0]     pcsource;
    logic           aluop1;
    logic           aluop0;
    logic [STW-1:0] state;

    modport master (
        input  op, mem_ready,
        output pcwrite, pcwritecond, iord, memread, memwrite, memtoreg,
               irwrite, regdst, regwrite, alusrca, alusrcb, pcsource,
               aluop1, aluop0, state
    );

    modport slave (
        output op, mem_ready,
        input  pcwrite, pcwritecond, iord, memread, memwrite, memtoreg,
               irwrite, regdst, regwrite, alusrca, alusrcb, pcsource,
               aluop1, aluop0, state
    );
endinterface

// File: rtl/mc_outdec.sv
// rtl/mc_outdec.sv - combinational state + mem_ready to control word decoder
module mc_outdec
    import mc_defs::*;
(
    input  logic [3:0] state,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl          = '0;
        ctrl.alusrcb  = SRCB_RT;
        ctrl.pcsource = PCSRC_ALU;
        ctrl.aluop    = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                // PC+4 and IR load commit on the same cycle memory returns the word
                ctrl.memread = 1'b1;
                ctrl.alusrcb = SRCB_FOUR;
                ctrl.pcwrite = mem_ready;
                ctrl.irwrite = mem_ready;
            end
            S_DECODE: begin
                ctrl.alusrcb = SRCB_IMMSH;
            end
            S_MEMADR: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl.memread = 1'b1;
                ctrl.iord    = 1'b1;
            end
            S_MEMWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.memtoreg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.memwrite = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_EXEC: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_RT;
                ctrl.aluop   = ALUOP_FUNCT;
            end
            S_RWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.regdst   = 1'b1;
            end
            S_BEQ: begin
                ctrl.alusrca     = 1'b1;
                ctrl.alusrcb     = SRCB_RT;
                ctrl.aluop       = ALUOP_SUB;
                ctrl.pcwritecond = 1'b1;
                ctrl.pcsource    = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pcwrite  = 1'b1;
                ctrl.pcsource = PCSRC_JUMP;
            end
            S_ADDIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
            end
            S_ADDIWB: begin
                ctrl.regwrite = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - main control FSM of the multicycle MIPS datapath
module multicycle_control
    import mc_defs::*;
#(
    parameter int OPW = 6,
    parameter int STW = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);

    logic [3:0]     state_q;
    logic [3:0]     state_d;
    logic [OPW-1:0] op_w;
    ctrl_t          ctrl;

    assign op_w = bus.op;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // op is only looked at in DECODE and MEMADR; elsewhere it is don't-care
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (is_mem_op(op_w))         state_d = S_MEMADR;
                else if (op_w == OP_RTYPE)   state_d = S_EXEC;
                else if (op_w == OP_BEQ)     state_d = S_BEQ;
                else if (op_w == OP_J)       state_d = S_JUMP;
                else if (op_w == OP_ADDI)    state_d = S_ADDIEX;
                else                         state_d = S_FETCH;
            end
            S_MEMADR: state_d = (op_w == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = bus.mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = bus.mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_RWB;
            S_RWB:    state_d = S_FETCH;
            S_BEQ:    state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    mc_outdec u_outdec (
        .state     (state_q),
        .mem_ready (bus.mem_ready),
        .ctrl      (ctrl)
    );

    // Keep FETCH from loading PC/IR while reset holds the machine
    assign bus.pcwrite     = ctrl.pcwrite & ~reset;
    assign bus.irwrite     = ctrl.irwrite & ~reset;
    assign bus.pcwritecond = ctrl.pcwritecond;
    assign bus.iord        = ctrl.iord;
    assign bus.memread     = ctrl.memread;
    assign bus.memwrite    = ctrl.memwrite;
    assign bus.memtoreg    = ctrl.memtoreg;
    assign bus.regdst      = ctrl.regdst;
    assign bus.regwrite    = ctrl.regwrite;
    assign bus.alusrca     = ctrl.alusrca;
    assign bus.alusrcb     = ctrl.alusrcb;
    assign bus.pcsource    = ctrl.pcsource;
    assign bus.aluop1      = ctrl.aluop[1];
    assign bus.aluop0      = ctrl.aluop[0];
    assign bus.state       = STW'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for the multicycle control FSM
module tb_multicycle_control;

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] JMP  = 6'b000010;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] ILL  = 6'b111111;

    typedef struct {
        string      tag;
        logic [3:0] st;
        logic [15:0] cw;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_bad = 0;
    exp_t sb[$];
    logic [15:0] cw_act;

    multicycle_control_if #(.OPW(6), .STW(4)) bus ();

    multicycle_control #(.OPW(6), .STW(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign cw_act = {bus.pcwrite, bus.pcwritecond, bus.iord, bus.memread, bus.memwrite,
                     bus.memtoreg, bus.irwrite, bus.regdst, bus.regwrite, bus.alusrca,
                     bus.alusrcb, bus.pcsource, bus.aluop1, bus.aluop0};

    // Expected control word per state, in the cw_act bit order
    function automatic logic [15:0] exp_cw(input logic [3:0] s, input logic mr);
        logic pcw = 0, pwc = 0, iord = 0, mrd = 0, mwr = 0, m2r = 0, irw = 0;
        logic rdst = 0, rw = 0, srca = 0;
        logic [1:0] srcb = 0, psrc = 0, aop = 0;
        case (s)
            4'd0:  begin mrd = 1; srcb = 2'b01; pcw = mr; irw = mr; end
            4'd1:  srcb = 2'b11;
            4'd2:  begin srca = 1; srcb = 2'b10; end
            4'd3:  begin mrd = 1; iord = 1; end
            4'd4:  begin rw = 1; m2r = 1; end
            4'd5:  begin mwr = 1; iord = 1; end
            4'd6:  begin srca = 1; aop = 2'b10; end
            4'd7:  begin rw = 1; rdst = 1; end
            4'd8:  begin srca = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
            4'd9:  begin pcw = 1; psrc = 2'b10; end
            4'd10: begin srca = 1; srcb = 2'b10; end
            4'd11: rw = 1;
            default: ;
        endcase
        return {pcw, pwc, iord, mrd, mwr, m2r, irw, rdst, rw, srca, srcb, psrc, aop};
    endfunction

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic [5:0] o, input logic mr, input logic [3:0] st);
        @(negedge clk);
        reset         = 1'b0;
        bus.op        = o;
        bus.mem_ready = mr;
        sb.push_back('{tag, st, exp_cw(st, mr)});
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                expect_eq({e.tag, "_state"}, 32'(bus.state), 32'(e.st));
                expect_eq({e.tag, "_cw"}, 32'(cw_act), 32'(e.cw));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout sb_left=%0d", sb.size());
        $fatal(1);
    end

    initial begin
        reset         = 1'b1;
        bus.op        = RT;
        bus.mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        expect_eq("rst_state", 32'(bus.state), 32'd0);
        expect_eq("rst_cw", 32'(cw_act), 32'(exp_cw(4'd0, 1'b0)));
        bus.mem_ready = 1'b1;
        #1;
        expect_eq("rst_cw_ready", 32'(cw_act), 32'(exp_cw(4'd0, 1'b1) & 16'h7dff));

        step("lw_f", LW, 1, 4'd0);
        step("lw_d", LW, 1, 4'd1);
        step("lw_a", LW, 1, 4'd2);
        step("lw_r", ILL, 1, 4'd3);
        step("lw_w", SW, 1, 4'd4);

        step("sw_fs", SW, 0, 4'd0);
        step("sw_f", SW, 1, 4'd0);
        step("sw_d", SW, 1, 4'd1);
        step("sw_a", SW, 1, 4'd2);
        for (int i = 0; i < 3; i++) step("sw_hold", ILL, 0, 4'd5);
        step("sw_wr", LW, 1, 4'd5);

        step("rt_f", RT, 1, 4'd0);
        step("rt_d", RT, 1, 4'd1);
        step("rt_x", LW, 1, 4'd6);
        step("rt_w", ILL, 1, 4'd7);

        step("beq_f", BEQ, 1, 4'd0);
        step("beq_d", BEQ, 1, 4'd1);
        step("beq_x", ILL, 1, 4'd8);
        step("j_f", JMP, 1, 4'd0);
        step("j_d", JMP, 1, 4'd1);
        step("j_x", LW, 1, 4'd9);

        step("addi_f", ADDI, 1, 4'd0);
        step("addi_d", ADDI, 1, 4'd1);
        step("addi_x", ILL, 1, 4'd10);
        step("addi_w", SW, 1, 4'd11);

        step("ill_f", ILL, 1, 4'd0);
        step("ill_d", ILL, 1, 4'd1);

        @(negedge clk);
        bus.mem_ready = 1'b0;
        force dut.state_q = 4'd13;
        sb.push_back('{"st13", 4'd13, exp_cw(4'd13, 1'b0)});
        #3;
        release dut.state_q;
        step("st13_next", ILL, 0, 4'd0);

        step("rsw_f", SW, 1, 4'd0);
        step("rsw_d", SW, 1, 4'd1);
        step("rsw_a", SW, 1, 4'd2);
        step("rsw_hold", SW, 0, 4'd5);
        #3;
        reset         = 1'b1;
        bus.mem_ready = 1'b1;
        #1;
        expect_eq("rst_mid_state", 32'(bus.state), 32'd0);
        expect_eq("rst_mid_memwrite", 32'(bus.memwrite), 32'd0);
        expect_eq("rst_mid_cw", 32'(cw_act), 32'(exp_cw(4'd0, 1'b1) & 16'h7dff));
        step("rel_f", SW, 1, 4'd0);
        step("rel_d", ILL, 1, 4'd1);
        step("rel_f2", ILL, 0, 4'd0);

        @(negedge clk);
        #3;
        expect_eq("sb_drain", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Main control FSM for the multicycle MIPS datapath. It sits directly upstream of the ALU control decoder and drives its aluop1/aluop0 inputs together with all datapath enables and multiplexer selects. It sequences fetch, decode, execute, memory and writeback per opcode. Every memory-access state holds on a memory-ready handshake.

Parameters:
OPW, 6, opcode field width (instr[31:26])
STW, 4, state register width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
op  input  OPW  opcode from instruction register
mem_ready  input  1  memory completes the current access this cycle
pcwrite  output  1  unconditional PC load
pcwritecond  output  1  PC load qualified by ALU zero (beq)
iord  output  1  memory address select: 0=PC, 1=ALUOut
memread  output  1  memory read strobe
memwrite  output  1  memory write strobe
memtoreg  output  1  register write data: 0=ALUOut, 1=MDR
irwrite  output  1  instruction register load
regdst  output  1  destination register: 0=rt, 1=rd
regwrite  output  1  register file write enable
alusrca  output  1  ALU A: 0=PC, 1=rs
alusrcb  output  2  ALU B: 00=rt, 01=const 4, 10=signext imm, 11=signext imm<<2
pcsource  output  2  PC source: 00=ALU, 01=ALUOut, 10=jump target
aluop1  output  1  to ALU control decoder
aluop0  output  1  to ALU control decoder
state  output  STW  current state, for debug and bench

Behaviour:
- Moore machine: outputs decode only the registered state, plus mem_ready where noted. Any output not listed for a state is 0.
- Reset: async; state<=FETCH immediately. Outputs take the FETCH values, but pcwrite and irwrite stay 0 while reset is high. A reset mid-instruction abandons the instruction with no partial write after deassert.
- FETCH(0): memread=1, alusrcb=01, aluop=00. irwrite=pcwrite=mem_ready. Stays in FETCH while mem_ready=0; moves to DECODE when mem_ready=1.
- DECODE(1): alusrcb=11, aluop=00 (branch target precompute). Next state by op:
  - 100011/101011 -> MEMADR
  - 000000 -> EXEC
  - 000100 -> BEQ
  - 000010 -> JUMP
  - 001000 -> ADDIEX
  - any other opcode -> FETCH (NOP; no register, memory or PC write).
- MEMADR(2): alusrca=1, alusrcb=10, aluop=00. Goes to MEMRD for op=100011, else MEMWR.
- MEMRD(3): memread=1, iord=1. Holds until mem_ready, then goes to MEMWB.
- MEMWB(4): regwrite=1, memtoreg=1, regdst=0. Then FETCH.
- MEMWR(5): memwrite=1, iord=1. Holds until mem_ready, then FETCH. memwrite stays high throughout the hold.
- EXEC(6): alusrca=1, alusrcb=00, aluop=10 (function field decides the operation, including NOR). Then RWB.
- RWB(7): regwrite=1, regdst=1, memtoreg=0. Then FETCH.
- BEQ(8): alusrca=1, alusrcb=00, aluop=01, pcwritecond=1, pcsource=01. Then FETCH.
- JUMP(9): pcwrite=1, pcsource=10. Then FETCH.
- ADDIEX(10): alusrca=1, alusrcb=10, aluop=00. Then ADDIWB.
- ADDIWB(11): regwrite=1, regdst=0, memtoreg=0. Then FETCH.
- Illegal state codes 12-15: all outputs 0; next state FETCH.
- aluop=11 is never produced.
- Cycles with mem_ready=1 throughout:
  - lw 5
  - sw 4
  - R-type 4
  - addi 4
  - beq 3
  - j 3
  - illegal opcode 2
- op is sampled only in DECODE and MEMADR, so op changes in other states have no effect.

Decomposition:
- Package mc_defs: opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI), the state encodings above, and the alusrcb/pcsource select codes.
- Sub-module mc_outdec: purely combinational state+mem_ready -> control-word decoder. The top module holds the state register and next-state logic.

Test Plan:
- Reset asserted mid-MEMWR, then released -> state=0 asynchronously, memwrite=0 at once; after release the first cycle shows memread=1 with no write.
- lw (op=100011), mem_ready tied 1 -> states 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4; 5 cycles total.
- sw with mem_ready low for 3 cycles in MEMWR -> state 5 held for 4 cycles with memwrite=1 and iord=1 throughout; FETCH follows.
- R-type (op=000000) -> aluop1=1, aluop0=0 only in EXEC; RWB has regwrite=1, regdst=1.
- beq then j -> BEQ shows aluop=01, pcwritecond=1, pcsource=01; JUMP shows pcwrite=1, pcsource=10; each instruction takes 3 cycles.
- Illegal opcode 111111, plus state register forced to 13 -> DECODE goes to FETCH; state 13 gives all outputs 0, then FETCH.
